mc_stage_ctrl: RTL and testbench
================================

# mc_stage_ctrl

Multicycle stage controller for the processor core. It loads instruction RAM through the fetch stage and then sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It generates per-stage enables, program counter write and select strobes, and a retired-instruction count. It sits beside the instruction-fetch stage: it drives `ld`, `pc_ctrl_sig` and `pc_we`, and receives `comp` as `load_done`.

## Interface
Parameters:
- `LOAD_TIMEOUT`, default 1024: number of LOAD cycles allowed without `load_done` before the controller faults.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset. Dominates every other input.
- `start`, input, 1: in IDLE, begin the IRAM load and then execution.
- `load_done`, input, 1: IRAM load complete (the fetch stage's `comp`).
- `hold`, input, 1: freeze in FETCH.
- `instr_class`, input, 3: decode class. 0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 HALT, 7 illegal.
- `br_taken`, input, 1: branch condition from the execute stage; valid in EXEC.
- `mem_ready`, input, 1: data-memory access complete.
- `ld`, output, 1: IRAM load enable, high throughout LOAD.
- `if_en`, `id_en`, `ex_en`, `mem_en`, `wb_en`, output, 1 each: stage enables.
- `pc_we`, output, 1: PC update strobe, high in the retire cycle.
- `pc_ctrl_sig`, output, 1: PC source select. 1 = `new_pc`, 0 = incremented PC. Meaningful only when `pc_we` is high.
- `state`, output, 3: current state encoding.
- `halted`, output, 1: in HALT.
- `fault`, output, 1: sticky; set on load timeout or illegal class.
- `retired`, output, `CNT_W`: instructions retired.

## Operation
State encoding: IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7.

Output decoding:
- Stage enables are decoded from the registered state. Exactly one enable is high in FETCH..WB; `ld` is high only in LOAD.
- `pc_we` and `pc_ctrl_sig` are combinational from state, the latched class and `br_taken`.

State transitions:
- IDLE: `start` moves to LOAD; otherwise stay.
- LOAD:
  - `load_done` moves to FETCH.
  - A load-cycle counter, cleared on entry, reaching `LOAD_TIMEOUT`-1 without `load_done` moves to HALT and sets `fault`.
- FETCH:
  - `hold`=1: stay, with `if_en`=0.
  - Otherwise `if_en`=1 and move to DECODE.
- DECODE: `id_en`=1 and `instr_class` is latched into `cls_q`.
  - Class 6 moves to HALT.
  - Class 7 moves to HALT and sets `fault`.
  - Any other class moves to EXEC.
- EXEC: `ex_en`=1; next state depends on `cls_q`.
  - NOP: retire, with `pc_ctrl_sig`=0, then FETCH.
  - BRANCH: retire, with `pc_ctrl_sig`=`br_taken`, then FETCH.
  - JUMP: retire, with `pc_ctrl_sig`=1, then FETCH.
  - ALU: move to WB.
  - LOAD or STORE: move to MEM.
- MEM: `mem_en` is held high until `mem_ready`. MEM has no timeout. When `mem_ready` is seen:
  - STORE: retire, then FETCH.
  - LOAD: move to WB.
- WB: `wb_en`=1; retire, then FETCH.
- HALT: all enables 0, `halted`=1. Leaves only on `rst`; `start` is ignored.

Retire cycle:
- `pc_we`=1 for exactly one cycle per instruction.
- `retired` increments by 1 in the same cycle.
- `retired` wraps modulo 2^`CNT_W` with no flag.

## Timing
- Reset values: `state`=IDLE, every output 0, `retired`=0, `fault`=0, `cls_q`=0, load counter 0.
- `rst` in any state returns to IDLE on the next edge, including mid-LOAD and mid-MEM, and clears `fault` and `retired`.
- `start` asserted in the same cycle as `rst`: `rst` wins.
- Cycles per instruction, FETCH to FETCH, with no hold and `mem_ready` already high:
  - NOP, BRANCH, JUMP: 3
  - ALU: 4
  - STORE: 4
  - LOAD: 5
  - Each cycle of `mem_ready`=0 adds one cycle.
- `load_done` in the first LOAD cycle gives FETCH on the next edge.
- `load_done` in the timeout cycle: `load_done` wins, and `fault` stays 0.
- `hold` is sampled only in FETCH. `instr_class` is sampled only in DECODE. `br_taken` is used only in EXEC.

## Test plan
- Reset then boot: `rst`=1 for 2 cycles, then `start`=1 for 1 cycle, then `load_done` after 5 cycles. Required: all outputs 0 during reset; `ld` high exactly 6 cycles; `state`=2 on the next cycle.
- Class sequence ALU, LOAD (`mem_ready` low 2 cycles), STORE, BRANCH taken, BRANCH not taken, JUMP. Required:
  - stage counts of 4, 7, 4, 3, 3, 3 cycles;
  - `pc_we` pulses 6 times;
  - `pc_ctrl_sig`=1, 0, 1 on the last three retirements;
  - `retired`=6.
- Load timeout with `LOAD_TIMEOUT`=8 and `load_done` never asserted. Required: HALT after 8 LOAD cycles, `fault`=1, `halted`=1; a later `start` has no effect.
- Class 7 at DECODE leads to HALT with `fault`=1. Class 6 leads to HALT with `fault`=0 and `retired` unchanged.
- `hold`=1 for 3 cycles in FETCH: `if_en` low for those cycles, then high once.
- Reset asserted in MEM while `mem_ready`=0: IDLE next cycle, and `retired`=0.
- With `CNT_W`=4, retire 17 NOPs: `retired`=1.

Source files
------------

// File: rtl/mc_stage_ctrl.sv
// Multicycle stage controller: IRAM load, then FETCH/DECODE/EXEC/MEM/WB sequencing.
// Drives stage enables, PC write/select strobes and a retired-instruction count.
module mc_stage_ctrl #(
  parameter int LOAD_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_done,
  input  logic             hold,
  input  logic [2:0]       instr_class,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             ld,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_we,
  output logic             pc_ctrl_sig,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int LCW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [LCW-1:0] LCNT_MAX = LCW'(LOAD_TIMEOUT - 1);

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ALU = 3'd1;
  localparam logic [2:0] C_LD  = 3'd2;
  localparam logic [2:0] C_ST  = 3'd3;
  localparam logic [2:0] C_BR  = 3'd4;
  localparam logic [2:0] C_JMP = 3'd5;
  localparam logic [2:0] C_HLT = 3'd6;
  localparam logic [2:0] C_ILL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_cls;
  logic [LCW-1:0]   r_lcnt;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;
  logic             w_set_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cls     <= 3'd0;
      r_lcnt    <= '0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_fault) r_fault <= 1'b1;
      if (pc_we) r_retired <= r_retired + CNT_W'(1);
      if (r_state == S_DECODE) r_cls <= instr_class;
      // Counter only runs while loading; any other state re-arms it.
      if (r_state == S_LOAD) r_lcnt <= r_lcnt + LCW'(1);
      else r_lcnt <= '0;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_set_fault = 1'b0;
    ld          = 1'b0;
    if_en       = 1'b0;
    id_en       = 1'b0;
    ex_en       = 1'b0;
    mem_en      = 1'b0;
    wb_en       = 1'b0;
    pc_we       = 1'b0;
    pc_ctrl_sig = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        ld = 1'b1;
        if (load_done) begin
          w_next = S_FETCH;
        end else if (r_lcnt == LCNT_MAX) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
        end
      end
      S_FETCH: begin
        if (!hold) begin
          if_en  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        id_en = 1'b1;
        if (instr_class == C_HLT) begin
          w_next = S_HALT;
        end else if (instr_class == C_ILL) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        ex_en = 1'b1;
        if (r_cls == C_ALU) begin
          w_next = S_WB;
        end else if (r_cls == C_LD || r_cls == C_ST) begin
          w_next = S_MEM;
        end else begin
          // NOP, BRANCH and JUMP retire straight out of EXEC.
          pc_we       = 1'b1;
          pc_ctrl_sig = (r_cls == C_JMP) |
                        ((r_cls == C_BR) & br_taken);
          w_next      = S_FETCH;
        end
      end
      S_MEM: begin
        mem_en = 1'b1;
        if (mem_ready) begin
          if (r_cls == C_ST) begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        wb_en  = 1'b1;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state   = r_state;
  assign halted  = (r_state == S_HALT);
  assign fault   = r_fault;
  assign retired = r_retired;

endmodule

// File: tb/tb_mc_stage_ctrl.sv
// Directed bench for mc_stage_ctrl (LOAD_TIMEOUT=8, CNT_W=4).
// Each task drives one scenario and checks hand-computed values inline.
module tb_mc_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       load_done = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] instr_class = 3'd0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b1;
  logic       ld, if_en, id_en, ex_en, mem_en, wb_en;
  logic       pc_we, pc_ctrl_sig, halted, fault;
  logic [2:0] state;
  logic [3:0] retired;

  int checks = 0;
  int errors = 0;

  mc_stage_ctrl #(.LOAD_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .load_done(load_done),
    .hold(hold), .instr_class(instr_class), .br_taken(br_taken),
    .mem_ready(mem_ready), .ld(ld), .if_en(if_en), .id_en(id_en),
    .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en), .pc_we(pc_we),
    .pc_ctrl_sig(pc_ctrl_sig), .state(state), .halted(halted),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_boot;
    rst = 1'b1; start = 1'b0; load_done = 1'b0;
    hold = 1'b0; mem_ready = 1'b1; br_taken = 1'b0;
    tick;
    rst = 1'b0; start = 1'b1;
    tick;
    start = 1'b0; load_done = 1'b1;
    tick;
    load_done = 1'b0;
  endtask

  // Runs one instruction from FETCH back to FETCH (bounded at 20 cycles).
  task automatic run_instr(input logic [2:0] c, input logic br,
                           input int mlow, output int n,
                           output int pw, output logic sel);
    int ml;
    ml = mlow; n = 0; pw = 0; sel = 1'b0;
    do begin
      hold = 1'b0; instr_class = c; br_taken = br;
      mem_ready = !(state == 3'd5 && ml > 0);
      if (state == 3'd5 && ml > 0) ml--;
      #1;
      if (pc_we) begin pw++; sel = pc_ctrl_sig; end
      tick;
      n++;
    end while (state != 3'd2 && n < 20);
    mem_ready = 1'b1;
  endtask

  task automatic test_reset;
    int nld;
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if ({state, ld, if_en, id_en, ex_en, mem_en, wb_en, pc_we,
           pc_ctrl_sig, halted, fault, retired} !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: state=%0d ld=%b fault=%b retired=%0d required all 0",
                 i, state, ld, fault, retired);
      end
    end
    rst = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    nld = 0;
    for (int i = 0; i < 6; i++) begin
      load_done = (i == 5);
      #1;
      if (ld) nld++;
      tick;
    end
    load_done = 1'b0;
    checks++;
    if (nld !== 6) begin
      errors++;
      $display("FAIL boot_ld_cycles: got %0d required 6", nld);
    end
    checks++;
    if (state !== 3'd2 || ld !== 1'b0) begin
      errors++;
      $display("FAIL boot_fetch: state=%0d ld=%b required 2/0", state, ld);
    end
  endtask

  task automatic test_stage_enables;
    logic [4:0] exp_en [5];
    logic [2:0] exp_st [5];
    exp_en = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    exp_st = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    do_boot;
    for (int i = 0; i < 5; i++) begin
      instr_class = 3'd2; mem_ready = 1'b1; hold = 1'b0;
      #1;
      checks++;
      if ({if_en, id_en, ex_en, mem_en, wb_en} !== exp_en[i] ||
          state !== exp_st[i] || ld !== 1'b0) begin
        errors++;
        $display("FAIL stage_en step%0d: st=%0d en=%b required st=%0d en=%b",
                 i, state, {if_en, id_en, ex_en, mem_en, wb_en},
                 exp_st[i], exp_en[i]);
      end
      tick;
    end
    checks++;
    if (state !== 3'd2 || retired !== 4'd1) begin
      errors++;
      $display("FAIL stage_en_end: st=%0d retired=%0d required 2/1", state, retired);
    end
  endtask

  task automatic test_class_seq;
    logic [2:0] cls [6];
    logic       brs [6];
    int         mls [6];
    int         expn [6];
    logic       exps [6];
    int n, pw, tot;
    logic sel;
    cls  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
    brs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mls  = '{0, 2, 0, 0, 0, 0};
    expn = '{4, 7, 4, 3, 3, 3};
    exps = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_boot;
    tot = 0;
    for (int i = 0; i < 6; i++) begin
      run_instr(cls[i], brs[i], mls[i], n, pw, sel);
      tot += pw;
      checks++;
      if (n !== expn[i] || pw !== 1 || sel !== exps[i]) begin
        errors++;
        $display("FAIL class_seq i%0d cls%0d: cycles=%0d pc_we=%0d sel=%b required %0d/1/%b",
                 i, cls[i], n, pw, sel, expn[i], exps[i]);
      end
    end
    checks++;
    if (tot !== 6 || retired !== 4'd6) begin
      errors++;
      $display("FAIL class_seq_total: pc_we=%0d retired=%0d required 6/6", tot, retired);
    end
  endtask

  task automatic test_timeout;
    int n;
    rst = 1'b1; tick;
    rst = 1'b0; start = 1'b1; load_done = 1'b0;
    tick;
    start = 1'b0;
    n = 0;
    while (state == 3'd1 && n < 20) begin
      #1;
      if (ld) n++;
      tick;
    end
    checks++;
    if (n !== 8 || state !== 3'd7 || fault !== 1'b1 || halted !== 1'b1) begin
      errors++;
      $display("FAIL load_timeout: cycles=%0d st=%0d fault=%b halted=%b required 8/7/1/1",
               n, state, fault, halted);
    end
    start = 1'b1;
    tick; tick;
    start = 1'b0;
    checks++;
    if (state !== 3'd7 || ld !== 1'b0 ||
        {if_en, id_en, ex_en, mem_en, wb_en} !== 5'd0) begin
      errors++;
      $display("FAIL halt_start_ignored: st=%0d ld=%b required 7/0", state, ld);
    end
    rst = 1'b1; tick; rst = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: st=%0d fault=%b required 0/0", state, fault);
    end
  endtask

  task automatic test_timeout_edge;
    rst = 1'b1; tick;
    rst = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_done = (i == 7);
      tick;
    end
    load_done = 1'b0;
    checks++;
    if (state !== 3'd2 || fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge: st=%0d fault=%b required 2/0", state, fault);
    end
  endtask

  task automatic test_halt_classes;
    int n, pw;
    logic sel;
    do_boot;
    tick;
    instr_class = 3'd7;
    #1;
    checks++;
    if (id_en !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL illegal_decode: st=%0d id_en=%b required 3/1", state, id_en);
    end
    tick;
    checks++;
    if (state !== 3'd7 || fault !== 1'b1 || halted !== 1'b1) begin
      errors++;
      $display("FAIL illegal_halt: st=%0d fault=%b halted=%b required 7/1/1",
               state, fault, halted);
    end
    do_boot;
    run_instr(3'd0, 1'b0, 0, n, pw, sel);
    tick;
    instr_class = 3'd6;
    tick;
    instr_class = 3'd0;
    checks++;
    if (state !== 3'd7 || fault !== 1'b0 || halted !== 1'b1 || retired !== 4'd1) begin
      errors++;
      $display("FAIL halt_class6: st=%0d fault=%b halted=%b retired=%0d required 7/0/1/1",
               state, fault, halted, retired);
    end
  endtask

  task automatic test_hold;
    do_boot;
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL fast_boot: st=%0d required 2", state);
    end
    for (int i = 0; i < 3; i++) begin
      hold = 1'b1;
      #1;
      checks++;
      if (if_en !== 1'b0 || state !== 3'd2) begin
        errors++;
        $display("FAIL hold_cyc%0d: if_en=%b st=%0d required 0/2", i, if_en, state);
      end
      tick;
    end
    hold = 1'b0;
    #1;
    checks++;
    if (if_en !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: if_en=%b required 1", if_en);
    end
    tick;
    checks++;
    if (state !== 3'd3 || if_en !== 1'b0) begin
      errors++;
      $display("FAIL hold_decode: st=%0d if_en=%b required 3/0", state, if_en);
    end
  endtask

  task automatic test_reset_mem;
    int n, pw;
    logic sel;
    do_boot;
    run_instr(3'd0, 1'b0, 0, n, pw, sel);
    instr_class = 3'd2;
    tick; tick; tick;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 3'd5 || mem_en !== 1'b1 || retired !== 4'd1) begin
      errors++;
      $display("FAIL mem_wait: st=%0d mem_en=%b retired=%0d required 5/1/1",
               state, mem_en, retired);
    end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mem_ready = 1'b1;
    checks++;
    if (state !== 3'd0 || retired !== 4'd0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_mem: st=%0d retired=%0d required 0/0", state, retired);
    end
  endtask

  task automatic test_wrap;
    int n, pw;
    logic sel;
    do_boot;
    for (int i = 0; i < 15; i++) run_instr(3'd0, 1'b0, 0, n, pw, sel);
    checks++;
    if (retired !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre: retired=%0d required 15", retired);
    end
    for (int i = 0; i < 2; i++) run_instr(3'd0, 1'b0, 0, n, pw, sel);
    checks++;
    if (retired !== 4'd1) begin
      errors++;
      $display("FAIL wrap_17: retired=%0d required 1", retired);
    end
  endtask

  initial begin
    test_reset;
    test_stage_enables;
    test_class_seq;
    test_timeout;
    test_timeout_edge;
    test_halt_classes;
    test_hold;
    test_reset_mem;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
